// File: rtl/sprite_pixel_compositor.sv
// sprite_pixel_compositor: scan position -> background/sprite RAM addresses,
// transparency merge and palette expansion to 24-bit RGB, 3-cycle latency.
// Ports: Clk, Reset (async, active-high); frame_start, pix_valid, DrawX/DrawY,
//   scroll_x, sprite_x/sprite_y, sprite_flip in; bg/spr_read_address out;
//   bg_data/spr_data in (1-cycle sync RAMs); rgb_out/rgb_valid out.
// Option: define SPRITE_DEBUG_BOX_EN to draw a magenta sprite bounding box.
module sprite_pixel_compositor #(
   parameter int         BG_W       = 640,
   parameter int         SPR_W      = 32,
   parameter int         SPR_H      = 32,
   parameter int         SPR_FRAMES = 8,
   parameter int         FRAME_DIV  = 8,
   parameter logic [3:0] TRANSP_IDX = 4'h0
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic [9:0]  scroll_x,
   input  logic [9:0]  sprite_x,
   input  logic [9:0]  sprite_y,
   input  logic        sprite_flip,
   output logic [17:0] bg_read_address,
   output logic [17:0] spr_read_address,
   input  logic [3:0]  bg_data,
   input  logic [3:0]  spr_data,
   output logic [23:0] rgb_out,
   output logic        rgb_valid
);

   localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
   localparam int AW = (SPR_FRAMES > 1) ? $clog2(SPR_FRAMES) : 1;
   localparam logic [DW-1:0] DIV_LAST  = DW'(FRAME_DIV - 1);
   localparam logic [AW-1:0] ANIM_LAST = AW'(SPR_FRAMES - 1);

   function automatic logic [23:0] pal_lut(input logic [3:0] idx);
      logic [23:0] c;
      case (idx)
         4'h0: c = 24'h000000;
         4'h1: c = 24'hFFFFFF;
         4'h2: c = 24'hF83800;
         4'h3: c = 24'hF87858;
         4'h4: c = 24'h00B800;
         4'h5: c = 24'hF8A0C8;
         4'h6: c = 24'h0058F8;
         4'h7: c = 24'hF8D878;
         4'h8: c = 24'h7C7C7C;
         4'h9: c = 24'h3060F8;
         4'hA: c = 24'hBCBCBC;
         4'hB: c = 24'h00A844;
         4'hC: c = 24'hD800CC;
         4'hD: c = 24'h58D854;
         4'hE: c = 24'h008888;
         default: c = 24'hF8B800;
      endcase
      return c;
   endfunction

   // Frame-boundary shadow state
   logic [9:0]    scroll_s, sx_s, sy_s;
   logic          flip_s;
   logic [DW-1:0] div_cnt;
   logic [AW-1:0] anim_frame;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         scroll_s   <= '0;
         sx_s       <= '0;
         sy_s       <= '0;
         flip_s     <= 1'b0;
         div_cnt    <= '0;
         anim_frame <= '0;
      end else if (frame_start) begin
         scroll_s <= (scroll_x >= 10'(BG_W)) ? '0 : scroll_x;
         sx_s     <= sprite_x;
         sy_s     <= sprite_y;
         flip_s   <= sprite_flip;
         if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (anim_frame == ANIM_LAST)
               anim_frame <= '0;
            else
               anim_frame <= anim_frame + 1'b1;
         end else begin
            div_cnt <= div_cnt + 1'b1;
         end
      end
   end

   // Stage-1 address math (always from the shadow copies)
   logic [10:0] col_raw, col, x_end, y_end;
   logic [9:0]  dx, dy, cx;
   logic        hit_c, box_c;
   logic [17:0] bg_addr_c, spr_addr_c;

   always_comb begin
      col_raw = {1'b0, DrawX} + {1'b0, scroll_s};
      col     = (col_raw >= 11'(BG_W)) ? col_raw - 11'(BG_W) : col_raw;
      bg_addr_c = 18'(DrawY) * 18'(BG_W) + 18'(col);

      // 11-bit ends keep sprites near x/y=1023 from wrapping to 0
      x_end = {1'b0, sx_s} + 11'(SPR_W);
      y_end = {1'b0, sy_s} + 11'(SPR_H);
      hit_c = pix_valid
            && (DrawX >= sx_s) && ({1'b0, DrawX} < x_end)
            && (DrawY >= sy_s) && ({1'b0, DrawY} < y_end);

      dx = DrawX - sx_s;
      dy = DrawY - sy_s;
      cx = flip_s ? (10'(SPR_W - 1) - dx) : dx;
      spr_addr_c = hit_c
                 ? 18'(anim_frame) * 18'(SPR_W * SPR_H)
                   + 18'(dy) * 18'(SPR_W) + 18'(cx)
                 : '0;

      box_c = hit_c && (dx == '0 || dx == 10'(SPR_W - 1)
                     || dy == '0 || dy == 10'(SPR_H - 1));
   end

   logic hit1, valid1, hit2, valid2;
`ifdef SPRITE_DEBUG_BOX_EN
   logic box1, box2;
`endif

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         bg_read_address  <= '0;
         spr_read_address <= '0;
         hit1             <= 1'b0;
         valid1           <= 1'b0;
         hit2             <= 1'b0;
         valid2           <= 1'b0;
`ifdef SPRITE_DEBUG_BOX_EN
         box1             <= 1'b0;
         box2             <= 1'b0;
`endif
      end else begin
         bg_read_address  <= bg_addr_c;
         spr_read_address <= spr_addr_c;
         hit1             <= hit_c;
         valid1           <= pix_valid;
         // RAM data for the stage-1 address arrives alongside these
         hit2             <= hit1;
         valid2           <= valid1;
`ifdef SPRITE_DEBUG_BOX_EN
         box1             <= box_c;
         box2             <= box1;
`endif
      end
   end

   logic [3:0]  sel_idx;
   logic [23:0] rgb_c;

   always_comb begin
      sel_idx = (hit2 && spr_data != TRANSP_IDX) ? spr_data : bg_data;
      rgb_c   = pal_lut(sel_idx);
`ifdef SPRITE_DEBUG_BOX_EN
      if (box2)
         rgb_c = 24'hFF00FF;
`else
      if (box_c && 1'b0)
         rgb_c = 24'hFF00FF;
`endif
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rgb_out   <= '0;
         rgb_valid <= 1'b0;
      end else begin
         rgb_out   <= valid2 ? rgb_c : 24'h000000;
         rgb_valid <= valid2;
      end
   end

endmodule

// File: tb/tb_sprite_pixel_compositor.sv
// Scoreboard bench for sprite_pixel_compositor with behavioural
// 1-cycle background/sprite RAMs; honours SPRITE_DEBUG_BOX_EN.
module tb_sprite_pixel_compositor;

   logic        Clk, Reset, frame_start, pix_valid, sprite_flip;
   logic [9:0]  DrawX, DrawY, scroll_x, sprite_x, sprite_y;
   logic [17:0] bg_read_address, spr_read_address;
   logic [3:0]  bg_data, spr_data;
   logic [23:0] rgb_out;
   logic        rgb_valid;

   int errors = 0;
   int checks = 0;
   int force_bg = -1;
   int force_spr = -1;
   int m_scroll, m_sx, m_sy, m_flip, m_div, m_anim;

   typedef struct { int bg; int spr; } ea_t;
   typedef struct { int v; int rgb; } er_t;
   ea_t qa[$];
   er_t qr[$];

   sprite_pixel_compositor dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
      .pix_valid(pix_valid), .DrawX(DrawX), .DrawY(DrawY),
      .scroll_x(scroll_x), .sprite_x(sprite_x), .sprite_y(sprite_y),
      .sprite_flip(sprite_flip), .bg_read_address(bg_read_address),
      .spr_read_address(spr_read_address), .bg_data(bg_data),
      .spr_data(spr_data), .rgb_out(rgb_out), .rgb_valid(rgb_valid)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic logic [3:0] bg_fn(input logic [17:0] a);
      return a[3:0] ^ a[9:6];
   endfunction

   function automatic logic [3:0] spr_fn(input logic [17:0] a);
      return a[4:1] + a[9:6];
   endfunction

   function automatic int pal(input int i);
      case (i)
         0: return 'h000000;  1: return 'hFFFFFF;
         2: return 'hF83800;  3: return 'hF87858;
         4: return 'h00B800;  5: return 'hF8A0C8;
         6: return 'h0058F8;  7: return 'hF8D878;
         8: return 'h7C7C7C;  9: return 'h3060F8;
         10: return 'hBCBCBC; 11: return 'h00A844;
         12: return 'hD800CC; 13: return 'h58D854;
         14: return 'h008888; default: return 'hF8B800;
      endcase
   endfunction

   // Behavioural synchronous-read RAMs
   always @(posedge Clk) begin
      bg_data  <= (force_bg >= 0) ? 4'(force_bg) : bg_fn(bg_read_address);
      spr_data <= (force_spr >= 0) ? 4'(force_spr) : spr_fn(spr_read_address);
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_scroll = 0; m_sx = 0; m_sy = 0;
      m_flip = 0; m_div = 0; m_anim = 0;
      qa.delete();
      qr.delete();
   endtask

   // One pixel-clock: check due results, drive a pixel, push its expectation
   task automatic step(input int fs, input int pv, input int x, input int y);
      ea_t ea;
      er_t er;
      int col, hit, dx, dy, cx, bgv, sv, sel;
      @(negedge Clk);
      if (qa.size() > 0) begin
         ea = qa.pop_front();
         check("bg_addr", 32'(bg_read_address), ea.bg);
         check("spr_addr", 32'(spr_read_address), ea.spr);
      end
      if (qr.size() == 3) begin
         er = qr.pop_front();
         check("rgb_valid", 32'(rgb_valid), er.v);
         check("rgb_out", 32'(rgb_out), er.rgb);
      end
      frame_start = 1'(fs);
      pix_valid   = 1'(pv);
      DrawX       = 10'(x);
      DrawY       = 10'(y);
      col = x + m_scroll;
      if (col >= 640) col -= 640;
      ea.bg = (y * 640 + col) & 'h3FFFF;
      hit = (pv != 0 && x >= m_sx && x < m_sx + 32
             && y >= m_sy && y < m_sy + 32) ? 1 : 0;
      dx = x - m_sx;
      dy = y - m_sy;
      cx = (m_flip != 0) ? 31 - dx : dx;
      ea.spr = (hit != 0) ? ((m_anim * 1024 + dy * 32 + cx) & 'h3FFFF) : 0;
      bgv = (force_bg >= 0) ? force_bg : int'(bg_fn(18'(ea.bg)));
      sv  = (force_spr >= 0) ? force_spr : int'(spr_fn(18'(ea.spr)));
      sel = (hit != 0 && sv != 0) ? sv : bgv;
      er.v = pv;
      er.rgb = (pv != 0) ? pal(sel) : 0;
`ifdef SPRITE_DEBUG_BOX_EN
      if (hit != 0 && (dx == 0 || dx == 31 || dy == 0 || dy == 31))
         er.rgb = 'hFF00FF;
`endif
      qa.push_back(ea);
      qr.push_back(er);
      if (fs != 0) begin
         m_scroll = (scroll_x >= 640) ? 0 : int'(scroll_x);
         m_sx = int'(sprite_x);
         m_sy = int'(sprite_y);
         m_flip = int'(sprite_flip);
         if (m_div == 7) begin
            m_div = 0;
            m_anim = (m_anim + 1) % 8;
         end else begin
            m_div++;
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   // Look at the result of the pixel driven in the last step
   task automatic peek_rgb(input string tag, input int exp);
      idle(2);
      @(posedge Clk);
      #1 check(tag, 32'(rgb_out), exp);
   endtask

   task automatic peek_addr(input string tag, input int bg, input int spr);
      @(posedge Clk);
      #1;
      if (bg >= 0) check({tag, "_bg"}, 32'(bg_read_address), bg);
      if (spr >= 0) check({tag, "_spr"}, 32'(spr_read_address), spr);
   endtask

   initial begin
      Reset = 1'b1;
      frame_start = 0; pix_valid = 0; sprite_flip = 0;
      DrawX = 0; DrawY = 0; scroll_x = 0; sprite_x = 0; sprite_y = 0;
      model_reset();
      @(negedge Clk);
      @(negedge Clk);
      check("rst_rgb", 32'(rgb_out), 0);
      check("rst_valid", 32'(rgb_valid), 0);
      check("rst_bg", 32'(bg_read_address), 0);
      check("rst_spr", 32'(spr_read_address), 0);
      Reset = 1'b0;

      // Scroll wrap and out-of-range scroll
      scroll_x = 10'd600;
      step(1, 0, 0, 0);
      step(0, 1, 100, 2);
      peek_addr("scroll600", 1340, -1);
      for (int x = 630; x < 650; x++) step(0, (x % 5 != 0) ? 1 : 0, x, 3);
      scroll_x = 10'd700;
      step(1, 0, 0, 0);
      step(0, 1, 100, 2);
      peek_addr("scroll700", 1380, -1);
      idle(4);

      // Transparency
      sprite_x = 10'd100; sprite_y = 10'd50;
      force_bg = 1; force_spr = 0;
      step(1, 0, 0, 0);
      step(0, 1, 110, 60);
      peek_rgb("transp_bg", 'hFFFFFF);
`ifdef SPRITE_DEBUG_BOX_EN
      step(0, 1, 100, 60);
      peek_rgb("debug_box", 'hFF00FF);
`endif
      force_spr = 5;
      step(0, 1, 110, 60);
      peek_rgb("opaque_spr", 'hF8A0C8);
      force_bg = -1; force_spr = -1;
      idle(1);
      for (int y = 49; y < 52; y++)
         for (int x = 96; x < 136; x++)
            step(0, (x % 7 != 0) ? 1 : 0, x, y);
      step(0, 1, 131, 81);
      step(0, 1, 132, 81);
      idle(4);

      // Flip and animation from a clean reset
      @(negedge Clk);
      Reset = 1'b1;
      model_reset();
      @(negedge Clk);
      Reset = 1'b0;
      sprite_flip = 1'b1;
      for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
      step(0, 1, 100, 50);
      peek_addr("anim1_flip", -1, 1055);
      for (int x = 98; x < 134; x++) step(0, 1, x, 70);
      for (int i = 0; i < 56; i++) step(1, 0, 0, 0);
      step(0, 1, 100, 50);
      peek_addr("anim_wrap", -1, 31);

      // Right edge near 1023 and tear-free shadowing
      sprite_flip = 1'b0;
      sprite_x = 10'd1010;
      step(1, 0, 0, 0);
      step(0, 1, 1015, 55);
      peek_addr("edge_hit", -1, 165);
      sprite_x = 10'd0;
      step(0, 1, 1015, 55);
      peek_addr("no_tear", -1, 165);
      for (int x = 1000; x < 1024; x++) step(0, 1, x, 81);
      for (int x = 1000; x < 1024; x++) step(0, 1, x, 82);

      // Reset in the middle of a line
      for (int x = 300; x < 306; x++) step(0, 1, x, 20);
      #2 Reset = 1'b1;
      #1;
      check("midrst_rgb", 32'(rgb_out), 0);
      check("midrst_valid", 32'(rgb_valid), 0);
      model_reset();
      @(negedge Clk);
      @(negedge Clk);
      Reset = 1'b0;
      idle(2);
      step(0, 1, 200, 10);
      step(0, 1, 201, 10);
      step(0, 1, 202, 10);
      @(posedge Clk);
      #1 check("post_rst_first", 32'(rgb_valid), 1);
      for (int x = 203; x < 210; x++) step(0, 1, x, 10);
      idle(4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
